// File: rtl/exp_arb_pkg.sv
// Shared constants for the exponential-core request arbiter.
// DATA_W           : operand/result width (IEEE-754 single precision)
// N_REQ_DEF        : default number of requesters
// MAX_INFLIGHT_DEF : default in-flight tag FIFO depth
// CORE_LATENCY     : pipeline latency of the exp core; the tag FIFO should be at
//                    least this deep to keep the core fully busy
package exp_arb_pkg;

    localparam int DATA_W           = 32;
    localparam int N_REQ_DEF        = 4;
    localparam int MAX_INFLIGHT_DEF = 8;
    localparam int CORE_LATENCY     = 6;

endpackage : exp_arb_pkg

// File: rtl/exp_tag_fifo.sv
// In-flight tag FIFO: remembers which requester issued each operation still
// inside the exp core, in issue order.
// Ports:
//   CLK      in  clock, rising edge
//   rst      in  asynchronous active-high reset
//   push     in  write push_tag (ignored when full)
//   push_tag in  requester ID of the operation being issued
//   pop      in  retire the oldest tag (ignored when empty)
//   pop_tag  out oldest tag (first-word fall-through, valid when !empty)
//   full     out count == DEPTH
//   empty    out count == 0
//   count    out number of stored tags
// DEPTH must be >= 2; pointers wrap explicitly so DEPTH need not be a power of two.
module exp_tag_fifo #(
    parameter int TAG_W = 2,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     push,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic                     pop,
    output logic [TAG_W-1:0]         pop_tag,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [TAG_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign count     = count_r;
    assign pop_tag   = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Tag storage and read/write pointers with modulo-DEPTH wrap.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_tag;
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule : exp_tag_fifo

// File: rtl/exp_req_arbiter.sv
// Shares one exp core between N_REQ requesters. A round-robin pick feeds the
// core's load/input_ready handshake; the winner's ID goes into a tag FIFO so each
// in-order core result can be steered back to the requester that issued it.
// Ports:
//   CLK, rst           clock (rising) and async active-high reset (shared with core)
//   en                 1 = new grants allowed; results always drain
//   req_valid/req_data per-requester operand valid and packed operands
//   req_ready          one-hot grant (combinational)
//   rsp_valid/rsp_data registered one-cycle result strobe and shared result bus
//   core_*             handshake to/from the exp core
//   busy               operations are in flight
//   err_spurious       sticky: result arrived with nothing in flight
//   err_overflow       sticky: operand accepted with the tag FIFO full
module exp_req_arbiter
    import exp_arb_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      core_start,
    output logic                      core_load,
    output logic [DATA_W-1:0]         core_in,
    input  logic                      core_input_ready,
    input  logic                      core_output_ready,
    input  logic [DATA_W-1:0]         core_out,
    output logic                      busy,
    output logic                      err_spurious,
    output logic                      err_overflow
);

    localparam int TAG_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    logic [TAG_W-1:0] rr_ptr_r;
    logic [TAG_W-1:0] win_s;
    logic             found_s;
    logic [TAG_W:0]   idx_s;
    logic             issue_s;
    logic             pop_s;
    logic [TAG_W-1:0] pop_tag_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [N_REQ-1:0] rsp_onehot_s;

    // Round-robin search from rr_ptr upward with wrap-around; the extra idx bit
    // holds rr_ptr + k before it is folded back into 0..N_REQ-1.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = {1'b0, rr_ptr_r} + (TAG_W + 1)'(k);
            if (idx_s >= (TAG_W + 1)'(N_REQ)) begin
                idx_s = idx_s - (TAG_W + 1)'(N_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_valid[idx_s[TAG_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[TAG_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // All combinational handshake outputs are forced low while rst is held.
    assign issue_s    = !rst && en && core_input_ready && !fifo_full_s && found_s;
    assign core_start = en && !rst;
    assign core_load  = issue_s;
    assign pop_s      = core_output_ready && !fifo_empty_s;
    assign busy       = (fifo_count_s != CNT_W'(0));

    // Grant and operand mux for the winner.
    always_comb begin
        req_ready = '0;
        core_in   = '0;
        if (issue_s) begin
            req_ready[win_s] = 1'b1;
            core_in          = req_data[win_s*DATA_W +: DATA_W];
        end else begin
            req_ready = '0;
            core_in   = '0;
        end
    end

    // Round-robin pointer moves just past the requester that was granted.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (issue_s) begin
            rr_ptr_r <= (win_s == TAG_W'(N_REQ - 1)) ? '0 : win_s + TAG_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    exp_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .CLK      (CLK),
        .rst      (rst),
        .push     (issue_s),
        .push_tag (win_s),
        .pop      (pop_s),
        .pop_tag  (pop_tag_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s)
    );

    // One-hot decode of the tag being retired.
    always_comb begin
        rsp_onehot_s             = '0;
        rsp_onehot_s[pop_tag_s]  = 1'b1;
    end

    // Registered response: strobe the owner one cycle after the core result;
    // rsp_data holds the last result between strobes.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (pop_s) begin
            rsp_valid <= rsp_onehot_s;
            rsp_data  <= core_out;
        end else begin
            rsp_valid <= '0;
            rsp_data  <= rsp_data;
        end
    end

    // Sticky error flags; overflow is unreachable because issue is gated by full.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            err_spurious <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (core_output_ready && fifo_empty_s) begin
                err_spurious <= 1'b1;
            end else begin
                err_spurious <= err_spurious;
            end
            if (core_load && core_input_ready && fifo_full_s) begin
                err_overflow <= 1'b1;
            end else begin
                err_overflow <= err_overflow;
            end
        end
    end

endmodule : exp_req_arbiter

// File: tb/tb_exp_req_arbiter.sv
// Directed self-checking bench for exp_req_arbiter (N_REQ=4, MAX_INFLIGHT=4).
// The exp core is replaced by directly driven handshake signals.
module tb_exp_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            CLK = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            core_start;
    logic            core_load;
    logic [DW-1:0]   core_in;
    logic            core_input_ready;
    logic            core_output_ready;
    logic [DW-1:0]   core_out;
    logic            busy;
    logic            err_spurious;
    logic            err_overflow;

    int n_cmp = 0;
    int n_err = 0;

    exp_req_arbiter #(
        .N_REQ        (N),
        .MAX_INFLIGHT (4)
    ) dut (
        .CLK               (CLK),
        .rst               (rst),
        .en                (en),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .core_start        (core_start),
        .core_load         (core_load),
        .core_in           (core_in),
        .core_input_ready  (core_input_ready),
        .core_output_ready (core_output_ready),
        .core_out          (core_out),
        .busy              (busy),
        .err_spurious      (err_spurious),
        .err_overflow      (err_overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_all_data();
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        end
    endtask

    initial begin
        // Reset: combinational outputs gated even with requests pending.
        rst = 1'b1; en = 1'b1; req_valid = 4'hF; req_data = '0; set_all_data();
        core_input_ready = 1'b1; core_output_ready = 1'b0; core_out = 32'h0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_core_load", 32'(core_load), 32'h0);
        check("rst_core_in", core_in, 32'h0);
        check("rst_core_start", 32'(core_start), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_errs", 32'({err_spurious, err_overflow}), 32'h0);
        tick(); tick();
        rst = 1'b0; req_valid = 4'h0;

        // Single requester 2.
        req_data[2*DW +: DW] = 32'h3F80_0000;
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_load", 32'(core_load), 32'h1);
        check("single_core_in", core_in, 32'h3F80_0000);
        tick();
        req_valid = 4'h0;
        #1;
        check("single_idle_ready", 32'(req_ready), 32'h0);
        check("single_idle_load", 32'(core_load), 32'h0);
        check("single_idle_in", core_in, 32'h0);
        check("single_busy", 32'(busy), 32'h1);
        tick();
        core_output_ready = 1'b1; core_out = 32'h402D_F854;
        #1;
        check("single_no_early_rsp", 32'(rsp_valid), 32'h0);
        tick();
        core_output_ready = 1'b0;
        #1;
        check("single_rsp_valid", 32'(rsp_valid), 32'h4);
        check("single_rsp_data", rsp_data, 32'h402D_F854);
        check("single_busy_done", 32'(busy), 32'h0);
        tick();
        check("single_rsp_once", 32'(rsp_valid), 32'h0);
        check("single_rsp_hold", rsp_data, 32'h402D_F854);

        // Fairness: rr_ptr is 3 after granting requester 2; 12 back-to-back issues,
        // each cycle also retiring the previous issue (push and pop together).
        set_all_data();
        for (int c = 0; c < 12; c++) begin
            req_valid = 4'hF;
            core_output_ready = (c > 0);
            core_out = 32'hE000_0000 + 32'(c);
            #1;
            check("fair_grant", 32'(req_ready), 32'(1) << ((3 + c) % 4));
            check("fair_core_in", core_in, 32'hA000_0000 + 32'((3 + c) % 4));
            if (c >= 2) begin
                check("fair_rsp_valid", 32'(rsp_valid), 32'(1) << ((3 + c - 2) % 4));
                check("fair_rsp_data", rsp_data, 32'hE000_0000 + 32'(c - 1));
            end else begin
                check("fair_rsp_idle", 32'(rsp_valid), 32'h0);
            end
            tick();
        end
        req_valid = 4'h0; core_output_ready = 1'b1; core_out = 32'hE000_000C;
        #1;
        check("fair_tail_ready", 32'(req_ready), 32'h0);
        check("fair_tail_rsp", 32'(rsp_valid), 32'h2);
        check("fair_tail_data", rsp_data, 32'hE000_000B);
        tick();
        core_output_ready = 1'b0;
        #1;
        check("fair_last_rsp", 32'(rsp_valid), 32'h4);
        check("fair_last_data", rsp_data, 32'hE000_000C);
        check("fair_busy", 32'(busy), 32'h0);

        // Full: four grants 3,0,1,2 then blocked until a result pops.
        req_valid = 4'hF;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("full_grant", 32'(req_ready), 32'(1) << ((3 + c) % 4));
            tick();
        end
        check("full_blocked", 32'(req_ready), 32'h0);
        check("full_no_load", 32'(core_load), 32'h0);
        tick();
        check("full_still_blocked", 32'(req_ready), 32'h0);
        core_output_ready = 1'b1; core_out = 32'hC000_0001;
        #1;
        check("full_pop_cycle_blocked", 32'(req_ready), 32'h0);
        tick();
        core_output_ready = 1'b0;
        #1;
        check("full_pop_rsp", 32'(rsp_valid), 32'h8);
        check("full_pop_data", rsp_data, 32'hC000_0001);
        check("full_regrant", 32'(req_ready), 32'h8);
        tick();
        check("full_no_overflow", 32'(err_overflow), 32'h0);

        // en=0 with four then three in flight: drain only.
        en = 1'b0;
        #1;
        check("en0_ready", 32'(req_ready), 32'h0);
        check("en0_load", 32'(core_load), 32'h0);
        check("en0_core_start", 32'(core_start), 32'h0);
        core_output_ready = 1'b1; core_out = 32'hC000_0002;
        tick();
        core_output_ready = 1'b0;
        #1;
        check("en0_rsp0", 32'(rsp_valid), 32'h1);
        check("en0_data0", rsp_data, 32'hC000_0002);
        check("en0_ready_after_pop", 32'(req_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            core_output_ready = 1'b1; core_out = 32'hD000_0000 + 32'(k);
            tick();
            core_output_ready = 1'b0;
            #1;
            check("en0_drain_rsp", 32'(rsp_valid), 32'(1) << (1 + k));
            check("en0_drain_data", rsp_data, 32'hD000_0000 + 32'(k));
            check("en0_drain_busy", 32'(busy), (k < 2) ? 32'h1 : 32'h0);
            check("en0_drain_ready", 32'(req_ready), 32'h0);
            tick();
            check("en0_drain_gap", 32'(rsp_valid), 32'h0);
        end

        // Spurious result with nothing in flight.
        en = 1'b1; req_valid = 4'h0;
        core_output_ready = 1'b1; core_out = 32'hBAD0_BAD0;
        tick();
        core_output_ready = 1'b0;
        #1;
        check("spur_no_rsp", 32'(rsp_valid), 32'h0);
        check("spur_flag", 32'(err_spurious), 32'h1);
        check("spur_data_hold", rsp_data, 32'hD000_0002);
        check("spur_no_overflow", 32'(err_overflow), 32'h0);

        // Reset mid-burst: rr_ptr is 0 after the last grant to requester 3.
        req_valid = 4'hF;
        #1;
        check("burst_grant0", 32'(req_ready), 32'h1);
        tick();
        core_output_ready = 1'b1; core_out = 32'hF000_0001;
        #1;
        check("burst_grant1", 32'(req_ready), 32'h2);
        tick();
        core_output_ready = 1'b0;
        #1;
        check("burst_rsp", 32'(rsp_valid), 32'h1);
        check("burst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_rsp_data", rsp_data, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_errs", 32'({err_spurious, err_overflow}), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        check("mid_rst_load", 32'(core_load), 32'h0);
        check("mid_rst_core_in", core_in, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_rr", 32'(req_ready), 32'h1);
        check("post_rst_busy", 32'(busy), 32'h0);
        req_valid = 4'h0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_exp_req_arbiter
